// File: rtl/nubus_error_log_pkg.sv
// Shared NuBus definitions: transfer status codes driven on /TM1,/TM0
// and the event-vector bit assignment used by the error collector.
package nubus_error_log_pkg;

  // Status codes as physical (active-low) /TM1,/TM0 levels.
  typedef enum logic [1:0] {
    TMN_TRY_AGAIN_LATER = 2'b00,
    TMN_TIMEOUT_ERROR   = 2'b01,
    TMN_ERROR           = 2'b10,
    TMN_COMPLETE        = 2'b11
  } tmn_status_e;

  // Position of the timeout flag inside the event vector {err, tmo}.
  localparam int ERRLOG_TMO_BIT = 0;

  // Priority encoder: timeout outranks generic errors, which outrank retry.
  function automatic tmn_status_e tmn_encode(input logic tmo,
                                             input logic any_err,
                                             input logic retry);
    if (tmo)          return TMN_TIMEOUT_ERROR;
    else if (any_err) return TMN_ERROR;
    else if (retry)   return TMN_TRY_AGAIN_LATER;
    else              return TMN_COMPLETE;
  endfunction

endpackage

// File: rtl/nubus_error_log_fifo.sv
// Log FIFO for the NuBus error collector (module nubus_errlog_fifo).
// First-word-fall-through: the head entry is held in a register so the
// CPU sees it the cycle after it is pushed. Pop is ignored when empty and
// a push into a full FIFO is only accepted if a pop frees a slot on the
// same edge. Flush overrides push and pop.
module nubus_errlog_fifo
  import nubus_error_log_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             nub_clkn,
  input  logic             nub_resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    next_rd;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign cnt   = cnt_q;
  assign dout  = head_q;

  // Resolve accepted operations, the next occupancy and the next head value.
  always_comb begin
    do_pop    = pop && !empty && !flush;
    do_push   = push && (!full || do_pop) && !flush;
    next_rd   = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_next  = cnt_q + CW'(do_push) - CW'(do_pop);
    head_next = '0;
    if (flush || cnt_next == '0)
      head_next = '0;
    else if (do_push && next_rd == wr_ptr)
      head_next = din;
    else
      head_next = mem[next_rd];
  end

  // Storage array; stale slots are never visible because the head is masked.
  always_ff @(negedge nub_clkn) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head, all cleared by reset or flush.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= next_rd;
      cnt_q  <= cnt_next;
      head_q <= head_next;
    end
  end

endmodule

// File: rtl/nubus_error_log.sv
// NuBus error collector: status-code encoder, sticky per-event flags with
// write-1-to-clear and maskable interrupt, overflow flag and a log FIFO of
// recent error events for the CPU to pop.
// Optional feature: define NUBUS_ERRLOG_TIMESTAMP_EN to tag each log entry
// with a free-running TSW-bit timestamp in the upper bits of the entry.
module nubus_error_log
  import nubus_error_log_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int DEPTH = 4,
  parameter int TSW   = 16,
  localparam int EW   = NSRC + 1,
`ifdef NUBUS_ERRLOG_TIMESTAMP_EN
  localparam int LOGW = EW + TSW,
`else
  localparam int LOGW = EW + 0 * TSW,
`endif
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            nub_clkn,
  input  logic            nub_resetn,
  input  logic            tmo_i,
  input  logic [NSRC-1:0] err_i,
  input  logic            tryagain_i,
  input  logic            cpu_eclr_i,
  input  logic [EW-1:0]   cpu_wclr_i,
  input  logic [EW-1:0]   cpu_imask_i,
  input  logic            cpu_log_pop_i,
  output logic [EW-1:0]   cpu_errors_o,
  output logic            cpu_irq_o,
  output logic            cpu_log_valid_o,
  output logic [LOGW-1:0] cpu_log_data_o,
  output logic [CW-1:0]   cpu_log_cnt_o,
  output logic            cpu_log_ovf_o,
  output logic [1:0]      mis_errorn_o
);

  logic [EW-1:0]   ev;
  logic            any_ev;
  logic [EW-1:0]   sticky_q;
  logic            irq_q;
  logic            ovf_q;
  logic [LOGW-1:0] log_din;
  logic            log_full;
  logic            log_empty;

  assign ev[ERRLOG_TMO_BIT] = tmo_i;
  assign ev[EW-1:1]         = err_i;
  assign any_ev             = |ev;

  assign mis_errorn_o    = tmn_encode(tmo_i, |err_i, tryagain_i);
  assign cpu_errors_o    = sticky_q;
  assign cpu_irq_o       = irq_q;
  assign cpu_log_ovf_o   = ovf_q;
  assign cpu_log_valid_o = !log_empty;

`ifdef NUBUS_ERRLOG_TIMESTAMP_EN
  logic [TSW-1:0] ts_q;

  // Free-running timestamp; the value before the edge is what a push records.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn)
      ts_q <= '0;
    else
      ts_q <= ts_q + TSW'(1);
  end

  assign log_din = {ts_q, ev};
`else
  assign log_din = ev;
`endif

  // Sticky flags: a new event wins over a same-cycle clear, global clear wins over all.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn)
      sticky_q <= '0;
    else if (cpu_eclr_i)
      sticky_q <= '0;
    else
      sticky_q <= (sticky_q & ~cpu_wclr_i) | ev;
  end

  // Interrupt follows the registered sticky flags through the mask one edge later.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn)
      irq_q <= 1'b0;
    else
      irq_q <= |(sticky_q & cpu_imask_i);
  end

  // Overflow latches when an event arrives at a full log with no pop to make room.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn)
      ovf_q <= 1'b0;
    else if (cpu_eclr_i)
      ovf_q <= 1'b0;
    else if (any_ev && log_full && !cpu_log_pop_i)
      ovf_q <= 1'b1;
  end

  nubus_errlog_fifo #(
    .WIDTH (LOGW),
    .DEPTH (DEPTH)
  ) u_log (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .flush      (cpu_eclr_i),
    .push       (any_ev),
    .pop        (cpu_log_pop_i),
    .din        (log_din),
    .dout       (cpu_log_data_o),
    .cnt        (cpu_log_cnt_o),
    .full       (log_full),
    .empty      (log_empty)
  );

endmodule

// File: tb/tb_nubus_error_log.sv
// Self-checking bench for nubus_error_log (NSRC=3, DEPTH=4, TSW=16).
// A queue-based model tracks sticky flags, irq, overflow and the log;
// a compare process checks every cycle, and directed scenarios add
// hand-computed literal expectations. Honours NUBUS_ERRLOG_TIMESTAMP_EN.
module tb_nubus_error_log;
  import nubus_error_log_pkg::*;

  localparam int NSRC  = 3;
  localparam int DEPTH = 4;
  localparam int TSW   = 16;
  localparam int EW    = NSRC + 1;
`ifdef NUBUS_ERRLOG_TIMESTAMP_EN
  localparam int LOGW  = EW + TSW;
`else
  localparam int LOGW  = EW;
`endif
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            nub_clkn = 1'b1;
  logic            nub_resetn = 1'b0;
  logic            tmo_i = 1'b0;
  logic [NSRC-1:0] err_i = '0;
  logic            tryagain_i = 1'b0;
  logic            cpu_eclr_i = 1'b0;
  logic [EW-1:0]   cpu_wclr_i = '0;
  logic [EW-1:0]   cpu_imask_i = '0;
  logic            cpu_log_pop_i = 1'b0;
  logic [EW-1:0]   cpu_errors_o;
  logic            cpu_irq_o;
  logic            cpu_log_valid_o;
  logic [LOGW-1:0] cpu_log_data_o;
  logic [CW-1:0]   cpu_log_cnt_o;
  logic            cpu_log_ovf_o;
  logic [1:0]      mis_errorn_o;

  int checks = 0;
  int errors = 0;
  bit checkEnable = 1'b0;

  // Model state
  logic [EW-1:0]   mSticky;
  logic            mIrq;
  logic            mOvf;
  logic [LOGW-1:0] mLog[$];
  logic [TSW-1:0]  mTs;
  logic [EW-1:0]   mEv;

  nubus_error_log dut (
    .nub_clkn        (nub_clkn),
    .nub_resetn      (nub_resetn),
    .tmo_i           (tmo_i),
    .err_i           (err_i),
    .tryagain_i      (tryagain_i),
    .cpu_eclr_i      (cpu_eclr_i),
    .cpu_wclr_i      (cpu_wclr_i),
    .cpu_imask_i     (cpu_imask_i),
    .cpu_log_pop_i   (cpu_log_pop_i),
    .cpu_errors_o    (cpu_errors_o),
    .cpu_irq_o       (cpu_irq_o),
    .cpu_log_valid_o (cpu_log_valid_o),
    .cpu_log_data_o  (cpu_log_data_o),
    .cpu_log_cnt_o   (cpu_log_cnt_o),
    .cpu_log_ovf_o   (cpu_log_ovf_o),
    .mis_errorn_o    (mis_errorn_o)
  );

  // Clock: state changes on the falling edge, bench samples after the rising edge.
  always #5 nub_clkn = ~nub_clkn;

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: behavioural rules of the collector, evaluated on each falling edge.
  always @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      mSticky = '0;
      mIrq    = 1'b0;
      mOvf    = 1'b0;
      mLog.delete();
      mTs     = '0;
    end else begin
      mEv  = {err_i, tmo_i};
      mIrq = |(mSticky & cpu_imask_i);
      if (cpu_eclr_i) begin
        mSticky = '0;
        mOvf    = 1'b0;
        mLog.delete();
      end else begin
        mSticky = (mSticky & ~cpu_wclr_i) | mEv;
        if (cpu_log_pop_i && mLog.size() > 0)
          void'(mLog.pop_front());
        if (mEv != '0) begin
          if (mLog.size() < DEPTH) begin
`ifdef NUBUS_ERRLOG_TIMESTAMP_EN
            mLog.push_back({mTs, mEv});
`else
            mLog.push_back(mEv);
`endif
          end else begin
            mOvf = 1'b1;
          end
        end
      end
      mTs = mTs + 1'b1;
    end
  end

  task automatic checkOutput();
    logic [1:0]      expStatus;
    logic [LOGW-1:0] expHead;
    if (tmo_i)           expStatus = TMN_TIMEOUT_ERROR;
    else if (err_i != 0) expStatus = TMN_ERROR;
    else if (tryagain_i) expStatus = TMN_TRY_AGAIN_LATER;
    else                 expStatus = TMN_COMPLETE;
    expHead = (mLog.size() > 0) ? mLog[0] : '0;
    compareVal("status",  32'(mis_errorn_o),    32'(expStatus));
    compareVal("errors",  32'(cpu_errors_o),    32'(mSticky));
    compareVal("irq",     32'(cpu_irq_o),       32'(mIrq));
    compareVal("ovf",     32'(cpu_log_ovf_o),   32'(mOvf));
    compareVal("cnt",     32'(cpu_log_cnt_o),   32'(mLog.size()));
    compareVal("valid",   32'(cpu_log_valid_o), 32'(mLog.size() != 0));
    compareVal("head",    32'(cpu_log_data_o),  32'(expHead));
  endtask

  // Compare process: checks all outputs against the model every cycle.
  always begin
    @(posedge nub_clkn);
    #2;
    if (checkEnable) checkOutput();
  end

  task automatic applyStimulus(input logic tmo, input logic [NSRC-1:0] err, input logic retry,
                               input logic eclr, input logic [EW-1:0] wclr, input logic pop);
    @(posedge nub_clkn);
    tmo_i         = tmo;
    err_i         = err;
    tryagain_i    = retry;
    cpu_eclr_i    = eclr;
    cpu_wclr_i    = wclr;
    cpu_log_pop_i = pop;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic clearAll();
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 4'b0000, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge nub_clkn);
    nub_resetn = 1'b1;
    checkEnable = 1'b1;
    idle();
    #2;
    compareVal("reset_errors", 32'(cpu_errors_o), 32'h0);
    compareVal("reset_cnt",    32'(cpu_log_cnt_o), 32'h0);
    compareVal("reset_status", 32'(mis_errorn_o), 32'(TMN_COMPLETE));

    // Single generic error
    applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b0);
    #2 compareVal("s1_status", 32'(mis_errorn_o), 32'(TMN_ERROR));
    idle();
    #2;
    compareVal("s1_errors", 32'(cpu_errors_o), 32'h4);
    compareVal("s1_cnt",    32'(cpu_log_cnt_o), 32'h1);
    compareVal("s1_data",   32'(cpu_log_data_o[3:0]), 32'h4);

    // Timeout together with an error
    clearAll();
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 1'b0);
    #2 compareVal("s2_status", 32'(mis_errorn_o), 32'(TMN_TIMEOUT_ERROR));
    idle();
    #2;
    compareVal("s2_cnt",  32'(cpu_log_cnt_o), 32'h1);
    compareVal("s2_data", 32'(cpu_log_data_o[3:0]), 32'h3);

    // Five back-to-back events overflow a four-entry log
    clearAll();
    for (int i = 1; i <= 5; i++)
      applyStimulus(1'b0, 3'(i), 1'b0, 1'b0, 4'b0000, 1'b0);
    idle();
    #2;
    compareVal("s3_cnt", 32'(cpu_log_cnt_o), 32'h4);
    compareVal("s3_ovf", 32'(cpu_log_ovf_o), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b1);
      #2 compareVal("s3_pop_data", 32'(cpu_log_data_o[3:0]), 32'(i * 2));
    end
    idle();
    #2 compareVal("s3_empty", 32'(cpu_log_valid_o), 32'h0);

    // Full log with simultaneous push and pop
    clearAll();
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, 3'(i), 1'b0, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b1);
    idle();
    #2;
    compareVal("s4_cnt", 32'(cpu_log_cnt_o), 32'h4);
    compareVal("s4_ovf", 32'(cpu_log_ovf_o), 32'h0);
    compareVal("s4_head", 32'(cpu_log_data_o[3:0]), 32'h2);
    repeat (3) applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b1);
    idle();
    #2 compareVal("s4_tail", 32'(cpu_log_data_o[3:0]), 32'hE);

    // Interrupt mask and write-1-to-clear racing a new timeout
    clearAll();
    cpu_imask_i = 4'b0001;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    idle();
    #2 compareVal("s5_irq_lat", 32'(cpu_irq_o), 32'h0);
    idle();
    #2 compareVal("s5_irq", 32'(cpu_irq_o), 32'h1);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0001, 1'b0);
    idle();
    #2 compareVal("s5_wclr_race", 32'(cpu_errors_o[0]), 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 4'b0001, 1'b0);
    idle();
    #2 compareVal("s5_wclr", 32'(cpu_errors_o), 32'h0);

    // Global clear beats a simultaneous error; retry is never logged
    applyStimulus(1'b0, 3'b100, 1'b0, 1'b1, 4'b0000, 1'b0);
    idle();
    #2;
    compareVal("s6_errors", 32'(cpu_errors_o), 32'h0);
    compareVal("s6_cnt",    32'(cpu_log_cnt_o), 32'h0);
    compareVal("s6_ovf",    32'(cpu_log_ovf_o), 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
    #2 compareVal("s6_retry", 32'(mis_errorn_o), 32'(TMN_TRY_AGAIN_LATER));
    idle();
    #2 compareVal("s6_retry_cnt", 32'(cpu_log_cnt_o), 32'h0);

    // Empty log with push and pop: pop ignored
    applyStimulus(1'b0, 3'b011, 1'b0, 1'b0, 4'b0000, 1'b1);
    idle();
    #2 compareVal("s7_cnt", 32'(cpu_log_cnt_o), 32'h1);

    // Asynchronous reset in the middle of operation
    applyStimulus(1'b0, 3'b101, 1'b0, 1'b0, 4'b0000, 1'b0);
    idle();
    @(posedge nub_clkn);
    #3 nub_resetn = 1'b0;
    #1;
    compareVal("s8_cnt",    32'(cpu_log_cnt_o), 32'h0);
    compareVal("s8_errors", 32'(cpu_errors_o), 32'h0);
    compareVal("s8_data",   32'(cpu_log_data_o), 32'h0);
    compareVal("s8_irq",    32'(cpu_irq_o), 32'h0);
    repeat (2) @(posedge nub_clkn);
    nub_resetn = 1'b1;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
    idle();
    #2 compareVal("s8_after", 32'(cpu_log_data_o[3:0]), 32'h1);
    repeat (3) idle();

    checkEnable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
